// File: rtl/pixel_ram.sv
// Pixel store: single-port synchronous RAM with a self-timed fill-to-CLEAR_VAL operation.
// Latency: one cycle from an accepted read to data_out/r_valid; a clear is busy for DEPTH+1 cycles.
// Backpressure: none on traffic; w_en/r_en/clear_start are dropped while busy is high.
//
// Ports:
//   clk, rst              single clock, synchronous active-high reset
//   w_en, r_en, address   write/read requests sharing one word address
//   data_in / data_out    write data / registered read data
//   r_valid               data_out was refreshed by a read accepted last cycle
//   clear_start           start a fill of the whole array with CLEAR_VAL
//   busy, clear_done      clear in progress / one-cycle completion pulse
module pixel_ram #(
  parameter int                DATA_W    = 8,
  parameter int                ADDR_W    = 12,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              w_en,
  input  logic              r_en,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              r_valid,
  input  logic              clear_start,
  output logic              busy,
  output logic              clear_done
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              rd_acc;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdat;

  // clear_start in IDLE swallows any same-cycle read/write; reset swallows everything.
  always_comb begin
    rd_acc   = 1'b0;
    mem_we   = 1'b0;
    mem_addr = address;
    mem_wdat = data_in;
    if (!rst) begin
      unique case (state)
        IDLE: begin
          rd_acc = r_en && !clear_start;
          mem_we = w_en && !clear_start;
        end
        CLEAR: begin
          mem_we   = 1'b1;
          mem_addr = clr_ptr;
          mem_wdat = CLEAR_VAL;
        end
        default: begin
          rd_acc = 1'b0;
          mem_we = 1'b0;
        end
      endcase
    end
  end

  // Array write port kept free of reset so the contents survive rst and the
  // storage maps onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdat;
    end
  end

  // Registered read; the non-blocking read of mem returns the pre-write word
  // when a write hits the same address in the same cycle (read-first).
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out <= '0;
    end else if (rd_acc) begin
      data_out <= mem[address];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      clr_ptr    <= '0;
      r_valid    <= 1'b0;
      busy       <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      r_valid <= rd_acc;
      unique case (state)
        IDLE: begin
          clear_done <= 1'b0;
          if (clear_start) begin
            state   <= CLEAR;
            clr_ptr <= '0;
            busy    <= 1'b1;
          end
        end
        CLEAR: begin
          // Pointer wraps to 0 on the same edge that leaves CLEAR.
          clr_ptr <= clr_ptr + 1'b1;
          if (&clr_ptr) begin
            state      <= FINISH;
            clear_done <= 1'b1;
          end
        end
        FINISH: begin
          state      <= IDLE;
          busy       <= 1'b0;
          clear_done <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          busy       <= 1'b0;
          clear_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_ram.sv
// Bench for pixel_ram: a wide instance (ADDR_W=12, CLEAR_VAL=0) and a small
// instance (ADDR_W=4, CLEAR_VAL=0x3C) share clock, reset and traffic; only the
// small one is ever cleared. Expected data comes from array models.
module tb_pixel_ram;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        w_en = 1'b0;
  logic        r_en = 1'b0;
  logic [11:0] address = '0;
  logic [7:0]  data_in = '0;
  logic        clear_start_a = 1'b0;
  logic        clear_start_b = 1'b0;

  logic [7:0]  a_dout, b_dout;
  logic        a_rv, b_rv, a_busy, b_busy, a_done, b_done;

  always #5 clk = ~clk;

  pixel_ram #(.DATA_W(8), .ADDR_W(12), .CLEAR_VAL(8'h00)) u_a (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .address(address),
    .data_in(data_in), .data_out(a_dout), .r_valid(a_rv),
    .clear_start(clear_start_a), .busy(a_busy), .clear_done(a_done)
  );

  pixel_ram #(.DATA_W(8), .ADDR_W(4), .CLEAR_VAL(8'h3C)) u_b (
    .clk(clk), .rst(rst), .w_en(w_en), .r_en(r_en), .address(address[3:0]),
    .data_in(data_in), .data_out(b_dout), .r_valid(b_rv),
    .clear_start(clear_start_b), .busy(b_busy), .clear_done(b_done)
  );

  int errors = 0;
  int checks = 0;

  // Reference contents: wide instance sparse, small instance dense with known flags.
  logic [7:0] model_a [int];
  logic [7:0] model_b [16];
  bit         known_b [16];
  bit         b_live = 1'b1;   // small instance is idle and accepting traffic

  // Expectations for the transaction just clocked in.
  logic [7:0] exp_a, exp_b;
  bit         kn_a, kn_b, ev_a, ev_b;

  // Apply one cycle of traffic, then derive expected results from the models.
  task automatic drive(input bit we, input bit re, input logic [11:0] ad,
                       input logic [7:0] din, input bit cs);
    w_en = we; r_en = re; address = ad; data_in = din; clear_start_b = cs;
    @(posedge clk);
    #1;
    ev_a  = re && !rst;
    kn_a  = model_a.exists(int'(ad));
    exp_a = kn_a ? model_a[int'(ad)] : 8'h00;
    if (we && !rst) model_a[int'(ad)] = din;
    ev_b  = b_live && re && !cs && !rst;
    kn_b  = known_b[ad[3:0]];
    exp_b = model_b[ad[3:0]];
    if (b_live && we && !cs && !rst) begin
      model_b[ad[3:0]] = din;
      known_b[ad[3:0]] = 1'b1;
    end
    w_en = 1'b0; r_en = 1'b0; clear_start_b = 1'b0;
  endtask

  task automatic fill_b_with_clear(input int upto);
    for (int k = 0; k < upto; k++) begin
      model_b[k] = 8'h3C;
      known_b[k] = 1'b1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    rst = 1'b0;
    checks++; if (a_dout !== 8'h00) begin errors++; $display("FAIL reset_a_dout got %h want 00", a_dout); end
    checks++; if (a_rv !== 1'b0) begin errors++; $display("FAIL reset_a_rv got %b want 0", a_rv); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy got %b want 0", a_busy); end
    checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_a_done got %b want 0", a_done); end
    checks++; if (b_dout !== 8'h00) begin errors++; $display("FAIL reset_b_dout got %h want 00", b_dout); end
    checks++; if (b_rv !== 1'b0) begin errors++; $display("FAIL reset_b_rv got %b want 0", b_rv); end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy got %b want 0", b_busy); end
    checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL reset_b_done got %b want 0", b_done); end
  endtask

  task automatic test_write_read;
    drive(1'b1, 1'b0, 12'h000, 8'hD0, 1'b0);
    drive(1'b1, 1'b0, 12'h009, 8'hD1, 1'b0);
    checks++; if (a_rv !== 1'b0) begin errors++; $display("FAIL wr_no_rv got %b want 0", a_rv); end
    drive(1'b0, 1'b1, 12'h009, 8'h00, 1'b0);
    checks++; if (a_rv !== 1'b1) begin errors++; $display("FAIL wr_rv got %b want 1", a_rv); end
    checks++; if (a_dout !== 8'hD1) begin errors++; $display("FAIL wr_dout got %h want d1", a_dout); end
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    checks++; if (a_rv !== 1'b0) begin errors++; $display("FAIL wr_rv_drop got %b want 0", a_rv); end
    checks++; if (a_dout !== 8'hD1) begin errors++; $display("FAIL wr_hold got %h want d1", a_dout); end
  endtask

  task automatic test_read_first;
    drive(1'b1, 1'b0, 12'h010, 8'h55, 1'b0);
    drive(1'b1, 1'b1, 12'h010, 8'hAA, 1'b0);
    checks++; if (a_dout !== 8'h55) begin errors++; $display("FAIL rf_old got %h want 55", a_dout); end
    checks++; if (a_rv !== 1'b1) begin errors++; $display("FAIL rf_rv got %b want 1", a_rv); end
    drive(1'b0, 1'b1, 12'h010, 8'h00, 1'b0);
    checks++; if (a_dout !== 8'hAA) begin errors++; $display("FAIL rf_new got %h want aa", a_dout); end
  endtask

  task automatic test_random;
    logic [7:0] hold_a = a_dout;
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            12'($urandom_range(0, 31)), 8'($urandom), 1'b0);
      checks++; if (a_rv !== ev_a) begin errors++; $display("FAIL rand_a_rv n=%0d got %b want %b", n, a_rv, ev_a); end
      checks++; if (b_rv !== ev_b) begin errors++; $display("FAIL rand_b_rv n=%0d got %b want %b", n, b_rv, ev_b); end
      if (ev_a && kn_a) hold_a = exp_a;
      if (ev_a && kn_a || !ev_a) begin
        checks++; if (a_dout !== hold_a) begin errors++; $display("FAIL rand_a_dout n=%0d got %h want %h", n, a_dout, hold_a); end
      end
      if (!ev_a && !kn_a) hold_a = a_dout;
      if (ev_a && !kn_a) hold_a = a_dout;
      if (ev_b && kn_b) begin
        checks++; if (b_dout !== exp_b) begin errors++; $display("FAIL rand_b_dout n=%0d got %h want %h", n, b_dout, exp_b); end
      end
    end
  endtask

  task automatic preload_b;
    for (int k = 0; k < 16; k++) drive(1'b1, 1'b0, 12'(k), 8'($urandom_range(0, 255)) | 8'h01, 1'b0);
  endtask

  task automatic readback_b(input string tag);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 1'b1, 12'(k), 8'h00, 1'b0);
      checks++; if (b_rv !== 1'b1) begin errors++; $display("FAIL %s_rv addr=%0d got %b want 1", tag, k, b_rv); end
      checks++; if (b_dout !== exp_b) begin errors++; $display("FAIL %s_dout addr=%0d got %h want %h", tag, k, b_dout, exp_b); end
    end
  endtask

  task automatic test_clear;
    int busy_cnt = 0, done_cnt = 0, done_at = 0, n = 0;
    preload_b();
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
    b_live = 1'b0;
    while (b_busy === 1'b1 && n < 40) begin
      n++;
      busy_cnt++;
      if (b_done === 1'b1) begin done_cnt++; done_at = n; end
      checks++; if (b_rv !== 1'b0) begin errors++; $display("FAIL clr_rv_low n=%0d got %b want 0", n, b_rv); end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 12'($urandom_range(0, 15)),
            8'($urandom), 1'($urandom_range(0, 1)));
    end
    checks++; if (busy_cnt != 17) begin errors++; $display("FAIL clr_busy_cycles got %0d want 17", busy_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL clr_done_pulses got %0d want 1", done_cnt); end
    checks++; if (done_at != 17) begin errors++; $display("FAIL clr_done_cycle got %0d want 17", done_at); end
    checks++; if (b_rv !== 1'b0) begin errors++; $display("FAIL clr_rv_after got %b want 0", b_rv); end
    b_live = 1'b1;
    fill_b_with_clear(16);
    readback_b("clr_read");
  endtask

  task automatic test_reset_mid_clear;
    bit saw_done = 1'b0;
    preload_b();
    drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b1);
    b_live = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
      if (b_done === 1'b1) saw_done = 1'b1;
    end
    checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL rmc_busy_before got %b want 1", b_busy); end
    rst = 1'b1;
    drive(1'b1, 1'b0, 12'h005, 8'hEE, 1'b0);
    rst = 1'b0;
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL rmc_busy got %b want 0", b_busy); end
    for (int c = 0; c < 20; c++) begin
      drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
      if (b_done === 1'b1 || b_busy === 1'b1) saw_done = 1'b1;
    end
    checks++; if (saw_done) begin errors++; $display("FAIL rmc_no_done got 1 want 0"); end
    b_live = 1'b1;
    fill_b_with_clear(5);
    readback_b("rmc_read");
  endtask

  task automatic test_priority;
    int n = 0;
    drive(1'b1, 1'b0, 12'h00F, 8'h11, 1'b0);
    drive(1'b1, 1'b1, 12'h00F, 8'h99, 1'b1);
    b_live = 1'b0;
    checks++; if (b_rv !== 1'b0) begin errors++; $display("FAIL pri_b_rv got %b want 0", b_rv); end
    checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL pri_b_busy got %b want 1", b_busy); end
    checks++; if (a_rv !== 1'b1) begin errors++; $display("FAIL pri_a_rv got %b want 1", a_rv); end
    while (b_busy === 1'b1 && n < 40) begin
      n++;
      drive(1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
    end
    checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL pri_busy_timeout got %b want 0", b_busy); end
    b_live = 1'b1;
    fill_b_with_clear(16);
    drive(1'b0, 1'b1, 12'h00F, 8'h00, 1'b0);
    checks++; if (b_dout !== 8'h3C) begin errors++; $display("FAIL pri_b_dout got %h want 3c", b_dout); end
    checks++; if (a_dout !== exp_a) begin errors++; $display("FAIL pri_a_dout got %h want %h", a_dout, exp_a); end
  endtask

  task automatic test_reset_keeps_mem;
    drive(1'b1, 1'b0, 12'h123, 8'h5A, 1'b0);
    drive(1'b1, 1'b0, 12'h7FF, 8'hA5, 1'b0);
    drive(1'b0, 1'b1, 12'h7FF, 8'h00, 1'b0);
    rst = 1'b1;
    drive(1'b0, 1'b1, 12'h123, 8'h00, 1'b0);
    rst = 1'b0;
    checks++; if (a_dout !== 8'h00) begin errors++; $display("FAIL rkm_dout got %h want 00", a_dout); end
    checks++; if (a_rv !== 1'b0) begin errors++; $display("FAIL rkm_rv got %b want 0", a_rv); end
    checks++; if (b_busy !== 1'b0 || b_done !== 1'b0) begin errors++; $display("FAIL rkm_b_flags got %b%b want 00", b_busy, b_done); end
    drive(1'b0, 1'b1, 12'h123, 8'h00, 1'b0);
    checks++; if (a_dout !== 8'h5A) begin errors++; $display("FAIL rkm_read1 got %h want 5a", a_dout); end
    drive(1'b0, 1'b1, 12'h7FF, 8'h00, 1'b0);
    checks++; if (a_dout !== 8'hA5) begin errors++; $display("FAIL rkm_read2 got %h want a5", a_dout); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_read_first();
    test_random();
    test_clear();
    test_reset_mid_clear();
    test_priority();
    test_reset_keeps_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_ram.md
PIXEL_RAM -- requirements
Module: pixel_ram

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the pixel word width in bits.
REQ-002 Parameter ADDR_W, default 12, SHALL set the address width; DEPTH = 2**ADDR_W words.
REQ-003 Parameter CLEAR_VAL, default 0 (DATA_W bits), SHALL set the word written to every location by a clear operation.
REQ-004 clk  in  1  SHALL be the single clock; all logic samples on its rising edge.
REQ-005 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-006 w_en  in  1  SHALL be the write request for the current cycle.
REQ-007 r_en  in  1  SHALL be the read request for the current cycle.
REQ-008 address  in  ADDR_W  SHALL be the word address shared by read and write.
REQ-009 data_in  in  DATA_W  SHALL be the write data.
REQ-010 data_out  out  DATA_W  SHALL be the registered read data.
REQ-011 r_valid  out  1  SHALL flag data_out as updated by a read accepted on the previous cycle.
REQ-012 clear_start  in  1  SHALL request a fill of the whole memory with CLEAR_VAL.
REQ-013 busy  out  1  SHALL be high while a clear is in progress.
REQ-014 clear_done  out  1  SHALL pulse high for one cycle when a clear completes.

Function
REQ-015 The FSM SHALL have states IDLE, CLEAR, and FINISH.
REQ-016 In IDLE, with w_en=1, the block SHALL write data_in to mem[address] at the clock edge.
REQ-017 In IDLE, with r_en=1, the block SHALL load data_out with mem[address] and assert r_valid on the next cycle (1-cycle latency).
REQ-018 r_valid SHALL be low in any cycle not following an accepted read.
REQ-019 data_out SHALL hold its last value when no read is accepted.
REQ-020 With w_en=1 and r_en=1 to the same address, the read SHALL return the old contents (read-first) and the write SHALL still occur.
REQ-021 In IDLE, clear_start=1 SHALL take priority over w_en/r_en in that cycle.
- Both requests are ignored.
- Transition to CLEAR with the internal clear pointer at 0.
REQ-022 In CLEAR, the block SHALL write CLEAR_VAL to mem[ptr] every cycle and increment ptr.
- Leave to FINISH after writing address DEPTH-1.
- A clear therefore takes exactly DEPTH cycles of writes.
REQ-023 In CLEAR, w_en, r_en, and clear_start SHALL be ignored and r_valid SHALL stay low.
REQ-024 busy SHALL be high in CLEAR and FINISH and low in IDLE.
REQ-025 In FINISH, clear_done SHALL be high for exactly one cycle, followed by an unconditional return to IDLE.
REQ-026 The clear pointer SHALL be ADDR_W bits wide; its wrap from DEPTH-1 to 0 SHALL coincide with leaving CLEAR.
REQ-027 The address SHALL be used unmodified; no out-of-range condition exists because DEPTH = 2**ADDR_W.
REQ-028 Memory SHALL be inferable as single-port synchronous block RAM: one write port, one registered read.

Reset
REQ-029 rst=1 SHALL force the following at the next edge:
- state to IDLE;
- clear pointer to 0;
- data_out to 0;
- r_valid, busy, and clear_done to 0.
REQ-030 rst SHALL NOT initialise memory contents.
REQ-031 rst asserted mid-clear SHALL abort the clear with no clear_done pulse; locations already written keep CLEAR_VAL.
REQ-032 rst SHALL take priority over all other inputs in the same cycle.

Verification
REQ-033 Write/read: write 0xD0 to 0x000 and 0xD1 to 0x009, then read 0x009 -> data_out=0xD1 and r_valid=1 exactly one cycle after r_en.
REQ-034 Read-first: hold 0x55 at 0x010, then w_en=r_en=1 at 0x010 with data_in=0xAA -> data_out=0x55; a following read -> 0xAA.
REQ-035 Clear with ADDR_W=4 and CLEAR_VAL=0x3C:
- pulse clear_start -> busy high for 17 cycles;
- clear_done high on the 17th cycle;
- all 16 reads then return 0x3C;
- w_en pulses issued while busy leave no effect.
REQ-036 Reset mid-clear with ADDR_W=4: assert rst on cycle 5 of CLEAR -> busy=0 and no clear_done pulse; addresses 0-4 = CLEAR_VAL; addresses 5-15 keep their prior data.
REQ-037 Priority: clear_start=1 together with w_en=1 (0x0F, data 0x99) in IDLE -> the write is dropped and 0x0F ends as CLEAR_VAL.
REQ-038 Reset values: after rst -> data_out=0, r_valid=0, busy=0, clear_done=0, and previously written memory data is still readable.
